ej32_mem8_resp: RTL

EJ32_MEM8_RESP -- requirements
Module: ej32_mem8_resp

---
 rtl/ej32_mem8_resp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ej32_mem8_resp.sv
// Byte memory with a registered bus read port, a host-fed input buffer (TIB)
// fill path, and an output-window tap that streams bus writes into a tx FIFO.
module ej32_mem8_resp #(
   parameter int ASZ   = 16,
   parameter int DEPTH = 8192,
   parameter int TIB   = 'h1000,
   parameter int TIBSZ = 'h400,
   parameter int OBUF  = 'h1400,
   parameter int OBSZ  = 'h400,
   parameter int FD    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [ASZ-1:0] ai,
   input  logic           we,
   input  logic [7:0]     vi,
   output logic [7:0]     vo,
   input  logic           rx_valid,
   input  logic [7:0]     rx_data,
   output logic           rx_ready,
   input  logic           tib_clr,
   output logic [ASZ-1:0] tib_cnt,
   output logic           tx_valid,
   output logic [7:0]     tx_data,
   input  logic           tx_ready,
   output logic           tx_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = (FD > 1) ? $clog2(FD) : 1;

   logic [7:0]  mem  [DEPTH];
   logic [7:0]  fifo [FD];
   logic [PW:0] wp;
   logic [PW:0] rp;

   logic [31:0] addr;
   logic [31:0] fill_addr;
   logic        bus_hit;
   logic        bus_wr;
   logic        obuf_hit;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic        fill;
   logic        fill_wr;

   // Address decode is done on a 32-bit view so parameter comparisons are exact.
   assign addr      = 32'(ai);
   assign bus_hit   = addr < 32'(DEPTH);
   assign bus_wr    = we && bus_hit;
   assign obuf_hit  = (addr >= 32'(OBUF)) && (addr < 32'(OBUF + OBSZ));
   assign push_req  = bus_wr && obuf_hit;

   // The shared write port belongs to the bus whenever we is high, so fill stalls.
   assign rx_ready  = !we && (32'(tib_cnt) < 32'(TIBSZ)) && !tib_clr;
   assign fill      = rx_valid && rx_ready;
   assign fill_addr = 32'(TIB) + 32'(tib_cnt);
   assign fill_wr   = fill && (fill_addr < 32'(DEPTH));

   assign empty    = (wp == rp);
   assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
   assign pop      = !empty && tx_ready;
   assign push     = push_req && (!full || pop);
   assign tx_valid = !empty;
   assign tx_data  = fifo[rp[PW-1:0]];

   always_ff @(posedge clk) begin
      if (bus_wr) begin
         mem[addr[AW-1:0]] <= vi;
      end else if (fill_wr) begin
         mem[fill_addr[AW-1:0]] <= rx_data;
      end
   end

   // Non-blocking read of mem gives read-first behaviour on a same-address write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vo <= '0;
      end else begin
         vo <= bus_hit ? mem[addr[AW-1:0]] : 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tib_cnt <= '0;
      end else if (tib_clr) begin
         tib_cnt <= '0;
      end else if (fill) begin
         tib_cnt <= tib_cnt + ASZ'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wp[PW-1:0]] <= vi;
      end
   end

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp     <= '0;
         rp     <= '0;
         tx_ovf <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push_req && !push) begin
            tx_ovf <= 1'b1;
         end
      end
   end

endmodule
